// File: rtl/async_fifo_rd_out_pkg.sv
// async_fifo_rd_out_pkg: shared state encoding and default widths for the async FIFO read-side output stage
//   state_t        S_EMPTY / S_ONE / S_TWO occupancy of the 2-entry skid buffer (2'b11 is illegal)
//   DEF_D_WIDTH    default FIFO data word width
//   DEF_CNT_WIDTH  default delivered-word counter width
package async_fifo_rd_out_pkg;
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } state_t;
  localparam int DEF_D_WIDTH   = 8;
  localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/async_fifo_rd_out_if.sv
// async_fifo_rd_out_if: FIFO read-port plus downstream valid/ready stream bundle
//   R_EMPTY, RD_DATA   FIFO empty flag and current read word (from read-pointer logic)
//   R_INC              pop request back to read-pointer logic
//   FLUSH              synchronous discard of buffered words
//   OUT_DATA/VALID     registered head word and its valid
//   OUT_READY          downstream accept
//   RD_COUNT           words accepted downstream since reset
//   master: the output stage; slave: the surrounding FIFO and consumer
interface async_fifo_rd_out_if
  import async_fifo_rd_out_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic                 R_EMPTY;
  logic [D_WIDTH-1:0]   RD_DATA;
  logic                 R_INC;
  logic                 FLUSH;
  logic [D_WIDTH-1:0]   OUT_DATA;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [CNT_WIDTH-1:0] RD_COUNT;
  modport master (
    input  R_EMPTY, RD_DATA, FLUSH, OUT_READY,
    output R_INC, OUT_DATA, OUT_VALID, RD_COUNT
  );
  modport slave (
    output R_EMPTY, RD_DATA, FLUSH, OUT_READY,
    input  R_INC, OUT_DATA, OUT_VALID, RD_COUNT
  );
endinterface

// File: rtl/async_fifo_rd_out.sv
// async_fifo_rd_out: read-domain output stage; pops the FIFO into a 2-entry skid buffer and drives a registered valid/ready stream
//   R_CLK  read-domain clock
//   R_RST  asynchronous active-low reset
//   rd     async_fifo_rd_out_if master: FIFO pop side (R_EMPTY, RD_DATA, R_INC), FLUSH,
//          stream side (OUT_DATA, OUT_VALID, OUT_READY) and RD_COUNT
module async_fifo_rd_out
  import async_fifo_rd_out_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic                 R_CLK,
  input logic                 R_RST,
  async_fifo_rd_out_if.master rd
);
  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [D_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 push, pop;
  // Push never looks at OUT_READY, so the upstream pointer has no combinational path from the consumer;
  // the S_TWO tail slot absorbs the word popped while the consumer stalls. Gated by R_RST so nothing pops during reset.
  assign push = R_RST & ~rd.R_EMPTY & (state_q != S_TWO) & ~rd.FLUSH;
  assign pop  = valid_q & rd.OUT_READY;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: if (push) begin
        state_d = S_ONE;
        head_d  = rd.RD_DATA;
      end
      S_ONE: begin
        if (push && pop) head_d = rd.RD_DATA;
        else if (push) begin
          state_d = S_TWO;
          tail_d  = rd.RD_DATA;
        end else if (pop) state_d = S_EMPTY;
      end
      S_TWO: if (pop) begin
        state_d = S_ONE;
        head_d  = tail_q;
      end
      default: state_d = S_EMPTY;
    endcase
    if (rd.FLUSH) state_d = S_EMPTY;
    valid_d = (state_d == S_ONE) || (state_d == S_TWO);
    cnt_d   = cnt_q + CNT_WIDTH'(pop);
  end
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end
  assign rd.R_INC     = push;
  assign rd.OUT_DATA  = head_q;
  assign rd.OUT_VALID = valid_q;
  assign rd.RD_COUNT  = cnt_q;
endmodule

// File: tb/tb_async_fifo_rd_out.sv
// tb_async_fifo_rd_out: directed bench for async_fifo_rd_out with a small upstream FIFO model and stream scoreboard
module tb_async_fifo_rd_out;
  import async_fifo_rd_out_pkg::*;
  logic       R_CLK = 1'b0;
  logic       R_RST = 1'b0;
  logic [7:0] mem [0:63];
  logic [5:0] rp, wp;
  logic [7:0] got [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  async_fifo_rd_out_if #(.D_WIDTH(8), .CNT_WIDTH(4)) rd ();
  async_fifo_rd_out #(.D_WIDTH(8), .CNT_WIDTH(4)) dut (.R_CLK(R_CLK), .R_RST(R_RST), .rd(rd));
  always #5 R_CLK = ~R_CLK;
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) rp <= '0;
    else if (rd.R_INC) rp <= rp + 6'd1;
  end
  assign rd.R_EMPTY = (rp == wp);
  assign rd.RD_DATA = mem[rp];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask
  task automatic step();
    if (rd.OUT_VALID && rd.OUT_READY) got.push_back(rd.OUT_DATA);
    tick();
  endtask
  task automatic do_reset();
    R_RST = 1'b0;
    rd.FLUSH = 1'b0;
    rd.OUT_READY = 1'b0;
    wp = '0;
    got.delete();
    #3;
  endtask
  task automatic release_rst();
    @(negedge R_CLK);
    R_RST = 1'b1;
    #1;
  endtask
  task automatic chk_seq(input string tag, input int n, input logic [7:0] first);
    chk({tag, "_n"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hdead, {24'h0, first + 8'(i)});
  endtask
  initial begin
    int inc_cnt, cyc;
    logic pv, pr;
    logic [7:0] pd;
    // reset holds everything off even with a word waiting
    do_reset();
    mem[0] = 8'hA5;
    wp = 6'd1;
    #1;
    chk("rst_inc", rd.R_INC, 0);
    chk("rst_valid", rd.OUT_VALID, 0);
    chk("rst_count", rd.RD_COUNT, 0);
    release_rst();
    tick();
    chk("rst_rel_valid", rd.OUT_VALID, 1);
    chk("rst_rel_data", rd.OUT_DATA, 8'hA5);
    // streaming 1..10
    do_reset();
    for (int i = 0; i < 10; i++) mem[i] = 8'(i + 1);
    wp = 6'd10;
    rd.OUT_READY = 1'b1;
    release_rst();
    for (int i = 0; i < 13; i++) step();
    chk_seq("stream", 10, 8'd1);
    chk("stream_count", rd.RD_COUNT, 10);
    chk("stream_valid_end", rd.OUT_VALID, 0);
    // backpressure: two pops then hold
    do_reset();
    for (int i = 0; i < 3; i++) mem[i] = 8'(i + 1);
    wp = 6'd3;
    release_rst();
    inc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (rd.R_INC) inc_cnt++;
      tick();
    end
    chk("bp_pops", inc_cnt, 2);
    chk("bp_state", dut.state_q, S_TWO);
    chk("bp_data", rd.OUT_DATA, 8'd1);
    chk("bp_valid", rd.OUT_VALID, 1);
    rd.OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk_seq("bp", 3, 8'd1);
    chk("bp_count", rd.RD_COUNT, 3);
    // empty boundary then one word
    do_reset();
    rd.OUT_READY = 1'b1;
    release_rst();
    for (int i = 0; i < 3; i++) begin
      chk("empty_inc", rd.R_INC, 0);
      chk("empty_valid", rd.OUT_VALID, 0);
      step();
    end
    mem[0] = 8'h3C;
    wp = 6'd1;
    #1;
    chk("single_inc", rd.R_INC, 1);
    for (int i = 0; i < 4; i++) step();
    chk_seq("single", 1, 8'h3C);
    chk("single_valid_end", rd.OUT_VALID, 0);
    chk("single_count", rd.RD_COUNT, 1);
    // flush while full with a pop in the same cycle
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    wp = 6'd4;
    release_rst();
    tick();
    tick();
    chk("fl_state", dut.state_q, S_TWO);
    rd.FLUSH = 1'b1;
    rd.OUT_READY = 1'b1;
    #1;
    chk("fl_inc", rd.R_INC, 0);
    tick();
    chk("fl_valid", rd.OUT_VALID, 0);
    chk("fl_count", rd.RD_COUNT, 1);
    rd.FLUSH = 1'b0;
    #1;
    chk("fl_resume_inc", rd.R_INC, 1);
    tick();
    chk("fl_resume_valid", rd.OUT_VALID, 1);
    chk("fl_resume_data", rd.OUT_DATA, 8'h33);
    // counter wrap on 4 bits with random backpressure and stream stability
    do_reset();
    for (int i = 0; i < 17; i++) mem[i] = 8'h40 + 8'(i);
    wp = 6'd17;
    release_rst();
    cyc = 0;
    while (got.size() < 17 && cyc < 400) begin
      rd.OUT_READY = 1'($urandom_range(0, 1));
      #1;
      if (rd.OUT_VALID && rd.OUT_READY) got.push_back(rd.OUT_DATA);
      pv = rd.OUT_VALID;
      pd = rd.OUT_DATA;
      pr = rd.OUT_READY;
      tick();
      if (pv && !pr) begin
        chk("stable_valid", rd.OUT_VALID, 1);
        chk("stable_data", rd.OUT_DATA, pd);
      end
      cyc++;
    end
    chk_seq("wrap", 17, 8'h40);
    chk("wrap_count", rd.RD_COUNT, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
